// File: rtl/enemy_fire_scheduler_if.sv
// Signal bundle between the game controller and the enemy fire scheduler.
// The master side drives frame/fire/slot status; the slave side returns the strobe and status.
interface enemy_fire_scheduler_if #(
    parameter int unsigned NUM_SLOTS = 4
) ();
    logic                 frame_tick;
    logic                 fire_req;
    logic                 defend;
    logic [NUM_SLOTS-1:0] slot_busy;
    logic [NUM_SLOTS-1:0] slot_hit;
    logic [NUM_SLOTS-1:0] attack;
    logic [3:0]           ammo;
    logic [1:0]           state;
    logic [7:0]           hit_count;
    logic                 pending;

    modport master (
        output frame_tick, fire_req, defend, slot_busy, slot_hit,
        input  attack, ammo, state, hit_count, pending
    );

    modport slave (
        input  frame_tick, fire_req, defend, slot_busy, slot_hit,
        output attack, ammo, state, hit_count, pending
    );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: latches fire requests, issues one shot per frame into a free slot
// (round-robin), and tracks cooldown, magazine reload and saturating hit count.
module enemy_fire_scheduler #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned COOLDOWN  = 8,
    parameter int unsigned MAG_SIZE  = 6,
    parameter int unsigned RELOAD    = 30
) (
    input logic                   clk,
    input logic                   rst_n,
    enemy_fire_scheduler_if.slave bus
);

    localparam int unsigned PtrW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        StReady    = 2'd0,
        StCooldown = 2'd1,
        StReload   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           counter_q, counter_d;
    logic [3:0]           ammo_q, ammo_d;
    logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 pending_q, pending_d;
    logic [NUM_SLOTS-1:0] attack_q, attack_d;
    logic [7:0]           hit_count_q, hit_count_d;

    logic                 sel_found;
    logic [PtrW-1:0]      sel_idx;
    logic [PtrW:0]        sum;
    logic [PtrW-1:0]      idx;
    logic                 issue;
    logic [8:0]           hit_sum;

    // First free slot at or after rr_ptr, wrapping modulo NUM_SLOTS.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            sum = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
            if (sum >= (PtrW+1)'(NUM_SLOTS)) begin
                sum = sum - (PtrW+1)'(NUM_SLOTS);
            end
            idx = sum[PtrW-1:0];
            if (!sel_found && !bus.slot_busy[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    assign issue = bus.frame_tick && (state_q == StReady) && pending_q && !bus.defend && sel_found;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        ammo_d    = ammo_q;
        rr_ptr_d  = rr_ptr_q;
        attack_d  = '0;
        pending_d = bus.fire_req ? 1'b1 : (issue ? 1'b0 : pending_q);

        unique case (state_q)
            StReady: begin
                if (issue) begin
                    attack_d[sel_idx] = 1'b1;
                    ammo_d            = ammo_q - 4'd1;
                    if ({1'b0, sel_idx} == (PtrW+1)'(NUM_SLOTS - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = sel_idx + PtrW'(1);
                    end
                    if (ammo_q == 4'd1) begin
                        state_d   = StReload;
                        counter_d = 8'(RELOAD);
                    end else begin
                        state_d   = StCooldown;
                        counter_d = 8'(COOLDOWN);
                    end
                end
            end
            StCooldown: begin
                if (bus.frame_tick) begin
                    if (counter_q <= 8'd1) begin
                        state_d   = StReady;
                        counter_d = 8'd0;
                    end else begin
                        counter_d = counter_q - 8'd1;
                    end
                end
            end
            StReload: begin
                if (bus.frame_tick) begin
                    if (counter_q <= 8'd1) begin
                        state_d   = StReady;
                        counter_d = 8'd0;
                        ammo_d    = 4'(MAG_SIZE);
                    end else begin
                        counter_d = counter_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d   = StReady;
                counter_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        hit_sum     = {1'b0, hit_count_q} + 9'($countones(bus.slot_hit));
        hit_count_d = hit_sum[8] ? 8'hff : hit_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StReady;
            counter_q   <= 8'd0;
            ammo_q      <= 4'(MAG_SIZE);
            rr_ptr_q    <= '0;
            pending_q   <= 1'b0;
            attack_q    <= '0;
            hit_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            ammo_q      <= ammo_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            attack_q    <= attack_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign bus.attack    = attack_q;
    assign bus.ammo      = ammo_q;
    assign bus.state     = state_q;
    assign bus.hit_count = hit_count_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler; expected strobes are queued when a shot is provoked
// and popped by a monitor when attack rises.
module tb_enemy_fire_scheduler;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] exp_q[$];

    enemy_fire_scheduler_if #(.NUM_SLOTS(4)) bus ();

    enemy_fire_scheduler #(
        .NUM_SLOTS(4),
        .COOLDOWN (8),
        .MAG_SIZE (6),
        .RELOAD   (30)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every nonzero strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.attack !== 4'b0000) begin
            if (exp_q.size() == 0) check("unexpected_attack", 32'(bus.attack), 32'h0);
            else                   check("attack", 32'(bus.attack), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        #1;
        check("strobe_latency", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_fire();
        @(negedge clk);
        bus.fire_req = 1'b1;
        @(negedge clk);
        bus.fire_req = 1'b0;
    endtask

    task automatic hit(input logic [3:0] v);
        @(negedge clk);
        bus.slot_hit = v;
        @(negedge clk);
        bus.slot_hit = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.fire_req   = 1'b0;
        bus.defend     = 1'b0;
        bus.slot_busy  = 4'b0000;
        bus.slot_hit   = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_attack", 32'(bus.attack), 32'h0);
        check("rst_ammo", 32'(bus.ammo), 32'd6);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_hits", 32'(bus.hit_count), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        rst_n = 1'b1;

        // Single pulse shot, then exactly 8 cooldown ticks.
        pulse_fire();
        check("pend_set", 32'(bus.pending), 32'd1);
        exp_q.push_back(4'b0001);
        tick();
        check("s1_ammo", 32'(bus.ammo), 32'd5);
        check("s1_state", 32'(bus.state), 32'd1);
        check("s1_pend_clr", 32'(bus.pending), 32'd0);
        ticks(7);
        check("cd_7", 32'(bus.state), 32'd1);
        tick();
        check("cd_8", 32'(bus.state), 32'd0);

        // Held request: full magazine in round-robin order, then reload.
        do_reset();
        @(negedge clk);
        bus.fire_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(4'(1 << (k % 4)));
            tick();
            check("mag_ammo", 32'(bus.ammo), 32'(5 - k));
            if (k < 5) begin
                check("mag_state", 32'(bus.state), 32'd1);
                ticks(8);
            end else begin
                check("mag_reload", 32'(bus.state), 32'd2);
            end
        end
        bus.fire_req = 1'b0;
        ticks(29);
        check("rl_29_state", 32'(bus.state), 32'd2);
        check("rl_29_ammo", 32'(bus.ammo), 32'd0);
        tick();
        check("rl_30_state", 32'(bus.state), 32'd0);
        check("rl_30_ammo", 32'(bus.ammo), 32'd6);

        // Busy slots: skip, block, then release.
        do_reset();
        bus.slot_busy = 4'b0101;
        pulse_fire();
        exp_q.push_back(4'b0010);
        tick();
        check("busy_ammo", 32'(bus.ammo), 32'd5);
        ticks(8);
        bus.slot_busy = 4'b1111;
        pulse_fire();
        tick();
        check("blk_pend", 32'(bus.pending), 32'd1);
        check("blk_ammo", 32'(bus.ammo), 32'd5);
        check("blk_state", 32'(bus.state), 32'd0);
        bus.slot_busy = 4'b0111;
        exp_q.push_back(4'b1000);
        tick();
        check("rel_ammo", 32'(bus.ammo), 32'd4);
        check("rel_pend", 32'(bus.pending), 32'd0);

        // Defend inhibits firing but not cooldown counting.
        bus.slot_busy = 4'b0000;
        ticks(8);
        bus.defend = 1'b1;
        pulse_fire();
        ticks(5);
        check("def_pend", 32'(bus.pending), 32'd1);
        check("def_ammo", 32'(bus.ammo), 32'd4);
        bus.defend = 1'b0;
        exp_q.push_back(4'b0001);
        tick();
        check("def_shot_ammo", 32'(bus.ammo), 32'd3);
        bus.defend = 1'b1;
        ticks(7);
        check("def_cd_7", 32'(bus.state), 32'd1);
        tick();
        check("def_cd_8", 32'(bus.state), 32'd0);
        bus.defend = 1'b0;

        // Saturating hit counter.
        for (int i = 0; i < 62; i++) hit(4'b1111);
        hit(4'b0011);
        check("hits_250", 32'(bus.hit_count), 32'd250);
        hit(4'b1011);
        check("hits_253", 32'(bus.hit_count), 32'd253);
        hit(4'b1111);
        check("hits_sat", 32'(bus.hit_count), 32'd255);
        hit(4'b1111);
        check("hits_hold", 32'(bus.hit_count), 32'd255);

        // Drain the magazine, then reset mid-reload at counter 12.
        bus.fire_req = 1'b1;
        exp_q.push_back(4'b0010);
        tick();
        ticks(8);
        exp_q.push_back(4'b0100);
        tick();
        ticks(8);
        exp_q.push_back(4'b1000);
        tick();
        bus.fire_req = 1'b0;
        check("drain_state", 32'(bus.state), 32'd2);
        ticks(18);
        check("rl12_state", 32'(bus.state), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(bus.state), 32'd0);
        check("arst_ammo", 32'(bus.ammo), 32'd6);
        check("arst_pend", 32'(bus.pending), 32'd0);
        check("arst_hits", 32'(bus.hit_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        check("post_rst_ammo", 32'(bus.ammo), 32'd6);
        check("post_rst_state", 32'(bus.state), 32'd0);

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 Parameter: NUM_SLOTS, 4, number of enemy-bullet slots scheduled (2..8).
REQ-002 Parameter: COOLDOWN, 8, frame ticks between consecutive shots (1..255).
REQ-003 Parameter: MAG_SIZE, 6, shots per magazine (1..15).
REQ-004 Parameter: RELOAD, 30, frame ticks to refill an empty magazine (1..255).
REQ-005 clk  input  1  clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 frame_tick  input  1  one-cycle pulse, once per game frame.
REQ-008 fire_req  input  1  enemy fire request, level or pulse.
REQ-009 defend  input  1  enemy defending; firing inhibited.
REQ-010 slot_busy  input  NUM_SLOTS  per-slot bullet-exists flag.
REQ-011 slot_hit  input  NUM_SLOTS  per-slot one-cycle hit pulse.
REQ-012 attack  output  NUM_SLOTS  one-hot one-cycle fire strobe to the selected slot.
REQ-013 ammo  output  4  shots remaining in magazine.
REQ-014 state  output  2  FSM state: 0 READY, 1 COOLDOWN, 2 RELOAD.
REQ-015 hit_count  output  8  saturating count of enemy bullet hits.
REQ-016 pending  output  1  latched, not-yet-served fire request.

Function
REQ-017 pending SHALL be set in any cycle fire_req=1 and cleared only in a cycle that issues a shot; fire_req=1 during the issuing cycle SHALL leave pending=1.
REQ-018 A shot SHALL issue only in a cycle with frame_tick=1, state=READY, pending=1 (registered value), defend=0, and at least one slot_busy bit 0.
REQ-019 Slot selection SHALL be round-robin: the first free slot at or after rr_ptr (mod NUM_SLOTS); after issuing slot k, rr_ptr SHALL become (k+1) mod NUM_SLOTS.
REQ-020 attack SHALL be registered: exactly one bit high for exactly one clk cycle, in the cycle after the issuing cycle; attack SHALL be 0 otherwise.
REQ-021 On issue, ammo SHALL decrement by 1; if the new value is 0, state SHALL go to RELOAD with counter=RELOAD, otherwise to COOLDOWN with counter=COOLDOWN.
REQ-022 COOLDOWN: the counter SHALL decrement on each frame_tick; on the tick where the counter equals 1, state SHALL return to READY.
REQ-023 RELOAD: the counter SHALL decrement on each frame_tick; on the tick where the counter equals 1, ammo SHALL be set to MAG_SIZE and state SHALL return to READY.
REQ-024 A blocked shot (defend=1 or all slots busy) SHALL consume no ammo, move no pointer, and leave pending set.
REQ-025 defend SHALL NOT pause COOLDOWN or RELOAD counting.
REQ-026 hit_count SHALL add popcount(slot_hit) each cycle, saturating at 255.
REQ-027 No combinational path SHALL exist from any input to attack.

Reset
REQ-028 On rst_n=0, asynchronously: state=READY, ammo=MAG_SIZE, counter=0, rr_ptr=0, pending=0, attack=0, hit_count=0.
REQ-029 Reset asserted mid-COOLDOWN/RELOAD or in the cycle attack is high SHALL abort immediately to REQ-028 values; no strobe SHALL follow reset release without a new fire_req.

Verification
REQ-030 Reset, fire_req pulse, tick -> attack=0001 one cycle later for one cycle, ammo=5, state=COOLDOWN; READY after exactly 8 further ticks.
REQ-031 fire_req held high, all slots free -> attack sequence 0001,0010,0100,1000,0001,0010 spaced 9 ticks apart; after the 6th, ammo=0, state=RELOAD; ammo=6, READY after 30 ticks.
REQ-032 slot_busy=0101, rr_ptr=0, fire -> attack=0010; next shot with slot_busy=1111 -> no strobe, pending=1, ammo unchanged; release slot_busy=0111 -> attack=1000 on next tick.
REQ-033 defend=1 with pending=1 for 5 ticks -> no attack, ammo unchanged; defend=0 -> shot on next tick.
REQ-034 slot_hit=1011 for one cycle with hit_count=250 -> 253; then slot_hit=1111 -> 255, stays 255.
REQ-035 rst_n asserted during RELOAD (counter=12) -> state=READY, ammo=6, pending=0 immediately; no attack after release.
